// File: rtl/qspi_arb.sv
// qspi_arb: round-robin sequencer for the shared QSPI pin group.
// Grants the bus to the instruction-fetch port (flash, ce0) or the data
// port (PSRAM, ce1) and runs one complete quad transaction per grant:
// CE latch, command, 24-bit address, dummy, data, deselect latch.
module qspi_arb #(
   parameter int FLASH_DUMMY = 6,
   parameter int PSRAM_DUMMY = 6
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        if_req,
   input  logic [23:0] if_addr,
   input  logic        if_size,
   output logic [15:0] if_rdata,
   output logic        if_ack,
   input  logic        d_req,
   input  logic        d_we,
   input  logic [23:0] d_addr,
   input  logic        d_size,
   input  logic [15:0] d_wdata,
   output logic [15:0] d_rdata,
   output logic        d_ack,
   output logic        le,
   output logic        sck,
   output logic [3:0]  dq_out,
   output logic [3:0]  dq_oe,
   input  logic [3:0]  dq_in
);

   // S_RST holds outputs at 0 during reset so INIT is visible for exactly
   // one clock after release.
   typedef enum logic [3:0] {
      S_RST, S_INIT, S_IDLE, S_SEL, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DESEL
   } state_t;

   state_t      state, nxt_state;
   logic [7:0]  cnt, nxt_cnt;
   logic        last_d;
   logic        cur_d, cur_we, cur_size;
   logic [23:0] cur_addr;
   logic [15:0] cur_wdata;
   logic [15:0] rx_buf, rx_nxt;
   logic        grant_d, wr_op, rd_sample, slot_nxt;
   logic [7:0]  dummy_clks, data_clks;

   function automatic logic [3:0] cmd_nib(input logic wr, input logic idx);
      logic [7:0] c;
      c = wr ? 8'h38 : 8'hEB;
      return idx ? c[3:0] : c[7:4];
   endfunction

   function automatic logic [3:0] addr_nib(input logic [23:0] a, input logic [2:0] idx);
      case (idx)
         3'd0:    return a[23:20];
         3'd1:    return a[19:16];
         3'd2:    return a[15:12];
         3'd3:    return a[11:8];
         3'd4:    return a[7:4];
         default: return a[3:0];
      endcase
   endfunction

   // First byte on the wire is wdata[7:0], high nibble first.
   function automatic logic [3:0] wdata_nib(input logic [15:0] w, input logic [1:0] idx);
      case (idx)
         2'd0:    return w[7:4];
         2'd1:    return w[3:0];
         2'd2:    return w[15:12];
         default: return w[11:8];
      endcase
   endfunction

   // Mirror of wdata_nib for the receive direction.
   function automatic logic [15:0] place_nib(input logic [15:0] b, input logic [1:0] idx,
                                             input logic [3:0] nib);
      logic [15:0] r;
      r = b;
      case (idx)
         2'd0:    r[7:4]   = nib;
         2'd1:    r[3:0]   = nib;
         2'd2:    r[15:12] = nib;
         default: r[11:8]  = nib;
      endcase
      return r;
   endfunction

   assign grant_d    = d_req && (!if_req || !last_d);
   assign wr_op      = cur_d && cur_we;
   assign dummy_clks = cur_d ? 8'(2 * PSRAM_DUMMY) : 8'(2 * FLASH_DUMMY);
   assign data_clks  = cur_size ? 8'd8 : 8'd4;
   assign rd_sample  = (state == S_DATA) && cnt[0] && !wr_op;
   assign rx_nxt     = place_nib(rx_buf, cnt[2:1], dq_in);
   assign slot_nxt   = (nxt_state == S_CMD) || (nxt_state == S_ADDR) ||
                       (nxt_state == S_DUMMY) || (nxt_state == S_DATA);

   // Next state and in-state clock counter; cnt[0] is the slot phase (0=A, 1=B).
   always_comb begin
      nxt_state = state;
      nxt_cnt   = cnt + 8'd1;
      case (state)
         S_RST:   begin nxt_state = S_INIT; nxt_cnt = '0; end
         S_INIT:  begin nxt_state = S_IDLE; nxt_cnt = '0; end
         S_IDLE: begin
            nxt_cnt = '0;
            if (if_req || d_req) nxt_state = S_SEL;
         end
         S_SEL:   begin nxt_state = S_CMD; nxt_cnt = '0; end
         S_CMD: begin
            if (cnt == 8'd3) begin nxt_state = S_ADDR; nxt_cnt = '0; end
         end
         S_ADDR: begin
            if (cnt == 8'd11) begin
               nxt_cnt   = '0;
               nxt_state = (wr_op || dummy_clks == 8'd0) ? S_DATA : S_DUMMY;
            end
         end
         S_DUMMY: begin
            if (cnt == dummy_clks - 8'd1) begin nxt_state = S_DATA; nxt_cnt = '0; end
         end
         S_DATA: begin
            if (cnt == data_clks - 8'd1) begin nxt_state = S_DESEL; nxt_cnt = '0; end
         end
         S_DESEL: begin nxt_state = S_IDLE; nxt_cnt = '0; end
         default: begin nxt_state = S_RST; nxt_cnt = '0; end
      endcase
   end

   // FSM state plus registered pin drive and port responses for the next cycle.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= S_RST;
         cnt      <= '0;
         last_d   <= 1'b0;
         le       <= 1'b0;
         sck      <= 1'b0;
         dq_out   <= 4'h0;
         dq_oe    <= 4'h0;
         if_ack   <= 1'b0;
         d_ack    <= 1'b0;
         if_rdata <= 16'h0;
         d_rdata  <= 16'h0;
      end else begin
         state <= nxt_state;
         cnt   <= nxt_cnt;
         le    <= (nxt_state == S_INIT) || (nxt_state == S_SEL) || (nxt_state == S_DESEL);
         sck   <= slot_nxt && nxt_cnt[0];
         case (nxt_state)
            S_INIT, S_DESEL: begin
               dq_out <= 4'b0011;
               dq_oe  <= 4'b0011;
            end
            S_SEL: begin
               // dq[0]=ce0_n, dq[1]=ce1_n: PSRAM pulls ce1 low, flash ce0.
               dq_out <= grant_d ? 4'b0001 : 4'b0010;
               dq_oe  <= 4'b0011;
            end
            S_CMD: begin
               dq_oe <= 4'hF;
               if (!nxt_cnt[0]) dq_out <= cmd_nib(wr_op, nxt_cnt[1]);
            end
            S_ADDR: begin
               dq_oe <= 4'hF;
               if (!nxt_cnt[0]) dq_out <= addr_nib(cur_addr, nxt_cnt[3:1]);
            end
            S_DATA: begin
               dq_oe <= wr_op ? 4'hF : 4'h0;
               if (!nxt_cnt[0]) dq_out <= wr_op ? wdata_nib(cur_wdata, nxt_cnt[2:1]) : 4'h0;
            end
            default: begin
               dq_out <= 4'h0;
               dq_oe  <= 4'h0;
            end
         endcase
         if_ack <= (state == S_DATA) && (nxt_state == S_DESEL) && !cur_d;
         d_ack  <= (state == S_DATA) && (nxt_state == S_DESEL) && cur_d;
         if (state == S_IDLE && nxt_state == S_SEL) last_d <= grant_d;
         // Last read nibble goes straight to the port so rdata is valid with ack.
         if (rd_sample && nxt_state == S_DESEL) begin
            if (cur_d) d_rdata  <= rx_nxt;
            else       if_rdata <= rx_nxt;
         end
      end
   end

   // Transaction fields captured at grant, plus the receive assembly buffer.
   always_ff @(posedge clk) begin
      if (state == S_IDLE && nxt_state == S_SEL) begin
         cur_d     <= grant_d;
         cur_we    <= grant_d && d_we;
         cur_addr  <= grant_d ? d_addr : if_addr;
         cur_size  <= grant_d ? d_size : if_size;
         cur_wdata <= d_wdata;
         rx_buf    <= 16'h0;
      end else if (rd_sample) begin
         rx_buf <= rx_nxt;
      end
   end

endmodule

// File: tb/tb_qspi_arb.sv
// Directed bench for qspi_arb with a small flash/PSRAM device model on the pins.
module tb_qspi_arb;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        if_req, if_size, if_ack;
   logic [23:0] if_addr;
   logic [15:0] if_rdata;
   logic        d_req, d_we, d_size, d_ack;
   logic [23:0] d_addr;
   logic [15:0] d_wdata, d_rdata;
   logic        le, sck;
   logic [3:0]  dq_out, dq_oe, dq_in;

   int n_chk = 0;
   int n_err = 0;

   qspi_arb dut (
      .clk(clk), .rst_n(rst_n),
      .if_req(if_req), .if_addr(if_addr), .if_size(if_size), .if_rdata(if_rdata), .if_ack(if_ack),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_size(d_size), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_ack(d_ack),
      .le(le), .sck(sck), .dq_out(dq_out), .dq_oe(dq_oe), .dq_in(dq_in)
   );

   always #5 clk = ~clk;

   // Device model: 1 = flash selected, 2 = PSRAM selected
   logic [1:0]  msel = 2'd0;
   int          sck_cnt = 0;
   logic [3:0]  nib_log [0:31];
   logic [1:0]  sel_val = 2'b11;
   int          desel_n = 0;
   int          grant_n = 0;
   logic [7:0]  grant_seq = 8'h0;
   logic [7:0]  fmem [0:511];
   logic [7:0]  pmem [0:63];
   logic [23:0] m_addr;
   logic [7:0]  m_cmd, m_byte;
   int          m_j, m_rj;

   assign m_addr = {nib_log[2], nib_log[3], nib_log[4], nib_log[5], nib_log[6], nib_log[7]};
   assign m_cmd  = {nib_log[0], nib_log[1]};
   assign m_j    = sck_cnt - 8;
   assign m_rj   = sck_cnt - 14;

   always_comb begin
      m_byte = 8'h00;
      if (msel == 2'd1)      m_byte = fmem[9'(m_addr[8:0] + 9'(m_rj / 2))];
      else if (msel == 2'd2) m_byte = pmem[6'(m_addr[5:0] + 6'(m_rj / 2))];
   end

   assign dq_in = (msel != 2'd0 && m_rj >= 0 && !(msel == 2'd2 && m_cmd == 8'h38)) ?
                  (m_rj[0] ? m_byte[3:0] : m_byte[7:4]) : 4'h0;

   always_ff @(posedge clk) begin
      if (le) begin
         case (dq_out[1:0])
            2'b10: begin
               msel <= 2'd1; sck_cnt <= 0; sel_val <= 2'b10;
               grant_seq <= {grant_seq[6:0], 1'b0}; grant_n <= grant_n + 1;
            end
            2'b01: begin
               msel <= 2'd2; sck_cnt <= 0; sel_val <= 2'b01;
               grant_seq <= {grant_seq[6:0], 1'b1}; grant_n <= grant_n + 1;
            end
            2'b11: begin msel <= 2'd0; sck_cnt <= 0; desel_n <= desel_n + 1; end
            default: ;
         endcase
      end else if (sck) begin
         sck_cnt <= sck_cnt + 1;
         if (dq_oe == 4'hF && sck_cnt < 32) begin
            nib_log[sck_cnt] <= dq_out;
            if (msel == 2'd2 && m_j >= 0 && m_cmd == 8'h38) begin
               if (m_j[0]) pmem[6'(m_addr[5:0] + 6'(m_j / 2))][3:0] <= dq_out;
               else        pmem[6'(m_addr[5:0] + 6'(m_j / 2))][7:4] <= dq_out;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One transaction starting in IDLE; cyc = ack cycle relative to cycle 0, -1 on timeout.
   task automatic xact(input logic is_d, input logic we, input logic [23:0] addr,
                       input logic sz, input logic [15:0] wd, output int cyc);
      @(posedge clk); #1;
      if (is_d) begin d_req = 1'b1; d_we = we; d_addr = addr; d_size = sz; d_wdata = wd; end
      else begin if_req = 1'b1; if_addr = addr; if_size = sz; end
      cyc = -1;
      for (int k = 1; k <= 200 && cyc < 0; k++) begin
         @(posedge clk); #1;
         if (is_d ? d_ack : if_ack) cyc = k;
      end
      if_req = 1'b0; d_req = 1'b0;
      @(posedge clk); #1;
      check("ack_one_cycle", {31'b0, (is_d ? d_ack : if_ack)}, 32'h0);
   endtask

   function automatic logic [31:0] nibs8(input int base);
      logic [31:0] r;
      r = '0;
      for (int i = 0; i < 8; i++) r = {r[27:0], nib_log[base + i]};
      return r;
   endfunction

   initial begin
      int cyc, acks, g0, ds0, ack_seen;
      logic [3:0] seq;
      for (int i = 0; i < 512; i++) fmem[i] = 8'h00;
      fmem[9'h100] = 8'h13;
      fmem[9'h101] = 8'h05;
      rst_n = 1'b0; if_req = 1'b0; if_addr = '0; if_size = 1'b0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_size = 1'b0; d_wdata = '0;

      // Reset values, then INIT for exactly one clock
      repeat (3) @(posedge clk);
      #1;
      check("rst_ctrl", {22'b0, le, sck, dq_out, dq_oe, if_ack, d_ack}, 32'h0);
      check("rst_rdata", {if_rdata, d_rdata}, 32'h0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("init_drive", {23'b0, le, sck, dq_out, dq_oe}, {23'b0, 2'b10, 4'b0011, 4'b0011});
      @(posedge clk); #1;
      check("idle_drive", {23'b0, le, sck, dq_out, dq_oe}, 32'h0);

      // Flash 2-byte read
      xact(1'b0, 1'b0, 24'h000100, 1'b1, 16'h0, cyc);
      check("fl2_cycle", cyc, 32'd38);
      check("fl2_rdata", {16'h0, if_rdata}, 32'h0000_0513);
      check("fl2_nibbles", nibs8(0), 32'hEB00_0100);
      check("fl2_ce", {30'b0, sel_val}, 32'h2);

      // PSRAM 2-byte write, then readback
      xact(1'b1, 1'b1, 24'h00002A, 1'b1, 16'hBEEF, cyc);
      check("pw2_cycle", cyc, 32'd26);
      check("pw2_ce", {30'b0, sel_val}, 32'h1);
      check("pw2_hdr", nibs8(0), 32'h3800_002A);
      check("pw2_data", {16'h0, nib_log[8], nib_log[9], nib_log[10], nib_log[11]}, 32'h0000_EFBE);
      xact(1'b1, 1'b0, 24'h00002A, 1'b1, 16'h0, cyc);
      check("pr2_cycle", cyc, 32'd38);
      check("pr2_rdata", {16'h0, d_rdata}, 32'h0000_BEEF);

      // PSRAM 1-byte write of A5, then 1-byte read
      xact(1'b1, 1'b1, 24'h000010, 1'b0, 16'h77A5, cyc);
      check("pw1_cycle", cyc, 32'd22);
      xact(1'b1, 1'b0, 24'h000010, 1'b0, 16'h0, cyc);
      check("pr1_cycle", cyc, 32'd34);
      check("pr1_rdata", {16'h0, d_rdata}, 32'h0000_00A5);
      check("if_rdata_hold", {16'h0, if_rdata}, 32'h0000_0513);

      // Flash 1-byte read
      xact(1'b0, 1'b0, 24'h000101, 1'b0, 16'h0, cyc);
      check("fl1_cycle", cyc, 32'd34);
      check("fl1_rdata", {16'h0, if_rdata}, 32'h0000_0005);
      check("d_rdata_hold", {16'h0, d_rdata}, 32'h0000_00A5);

      // Reset during the address phase of a flash read
      ack_seen = 0;
      @(posedge clk); #1;
      if_req = 1'b1; if_addr = 24'h000100; if_size = 1'b1;
      repeat (10) begin
         @(posedge clk); #1;
         if (if_ack) ack_seen++;
      end
      rst_n = 1'b0; if_req = 1'b0;
      @(posedge clk); #1;
      check("midrst_out", {23'b0, le, sck, dq_out, dq_oe}, 32'h0);
      repeat (2) begin
         @(posedge clk); #1;
         if (if_ack) ack_seen++;
      end
      rst_n = 1'b1;
      @(posedge clk); #1;
      if (if_ack) ack_seen++;
      check("midrst_init", {23'b0, le, sck, dq_out, dq_oe}, {23'b0, 2'b10, 4'b0011, 4'b0011});
      @(posedge clk); #1;
      if (if_ack) ack_seen++;
      check("midrst_noack", ack_seen, 32'd0);
      xact(1'b0, 1'b0, 24'h000100, 1'b1, 16'h0, cyc);
      check("post_rst_cycle", cyc, 32'd38);
      check("post_rst_rdata", {16'h0, if_rdata}, 32'h0000_0513);

      // Both requests held: grants alternate d, if, d, if
      g0 = grant_n; ds0 = desel_n; acks = 0; seq = 4'h0;
      @(posedge clk); #1;
      d_req = 1'b1; d_we = 1'b0; d_addr = 24'h000010; d_size = 1'b0;
      if_req = 1'b1; if_addr = 24'h000100; if_size = 1'b1;
      for (int k = 0; k < 400 && acks < 4; k++) begin
         @(posedge clk); #1;
         if (d_ack)  begin seq = {seq[2:0], 1'b1}; acks++; end
         if (if_ack) begin seq = {seq[2:0], 1'b0}; acks++; end
         if (acks >= 4) begin d_req = 1'b0; if_req = 1'b0; end
      end
      d_req = 1'b0; if_req = 1'b0;
      @(posedge clk); #1;
      check("rr_ack_count", acks, 32'd4);
      check("rr_ack_order", {28'b0, seq}, 32'hA);
      check("rr_grant_order", {28'b0, grant_seq[3:0]}, 32'hA);
      check("rr_grants", grant_n - g0, 32'd4);
      check("rr_desels", desel_n - ds0, 32'd4);
      check("rr_rdata", {d_rdata, if_rdata}, 32'h00A5_0513);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
